// File: rtl/rvh_l1d_mshr_retire.sv
// L1D MSHR release side: per-entry FREE/WAIT/DONE lifecycle, stored line address,
// and a round-robin retire offer to the refill-write path over valid/ready.
module rvh_l1d_mshr_retire #(
   parameter int N_MSHR      = 4,
   parameter int N_MSHR_W    = 2,
   parameter int LINE_ADDR_W = 26
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alloc_vld_i,
   input  logic [N_MSHR_W-1:0]    alloc_id_i,
   input  logic [LINE_ADDR_W-1:0] alloc_line_addr_i,
   input  logic                   refill_done_vld_i,
   input  logic [N_MSHR_W-1:0]    refill_done_id_i,
   output logic                   retire_vld_o,
   input  logic                   retire_rdy_i,
   output logic [N_MSHR_W-1:0]    retire_id_o,
   output logic [LINE_ADDR_W-1:0] retire_line_addr_o,
   output logic [N_MSHR-1:0]      mshr_bank_valid_o,
   output logic [N_MSHR-1:0]      done_pending_o,
   output logic                   err_o
);

   // Retire handshake: a transfer happens on every clk edge where retire_vld_o and
   // retire_rdy_i are both high. Once offered, retire_vld_o/retire_id_o/retire_line_addr_o
   // hold until that transfer; only reset withdraws an offer.

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                 st_q     [N_MSHR];
   logic [LINE_ADDR_W-1:0] addr_q   [N_MSHR];
   logic [N_MSHR_W-1:0]    rr_ptr_q;
   logic [N_MSHR_W-1:0]    lock_id_q;
   logic                   lock_q;
   logic                   err_q;
   logic [N_MSHR_W-1:0]    pick_id;
   logic                   any_done;
   logic                   handshake;

   // Scan downward so the last hit kept is the one nearest rr_ptr.
   always_comb begin
      logic [N_MSHR_W-1:0] idx;
      any_done = 1'b0;
      pick_id  = '0;
      idx      = '0;
      for (int i = N_MSHR - 1; i >= 0; i--) begin
         idx = rr_ptr_q + N_MSHR_W'(i);
         if (st_q[idx] == ST_DONE) begin
            any_done = 1'b1;
            pick_id  = idx;
         end
      end
   end

   assign retire_vld_o       = lock_q | any_done;
   assign retire_id_o        = lock_q ? lock_id_q : pick_id;
   assign retire_line_addr_o = addr_q[retire_id_o];
   assign handshake          = retire_vld_o & retire_rdy_i;
   assign err_o              = err_q;

   always_comb begin
      for (int i = 0; i < N_MSHR; i++) begin
         mshr_bank_valid_o[i] = (st_q[i] != ST_FREE);
         done_pending_o[i]    = (st_q[i] == ST_DONE);
      end
   end

   // All legality checks use pre-cycle state, so legal same-cycle events never
   // write the same entry and the writes below cannot collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_MSHR; i++) begin
            st_q[i]   <= ST_FREE;
            addr_q[i] <= '0;
         end
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (handshake) begin
            st_q[retire_id_o] <= ST_FREE;
            rr_ptr_q          <= retire_id_o + N_MSHR_W'(1);
            lock_q            <= 1'b0;
         end else if (retire_vld_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= retire_id_o;
         end

         if (alloc_vld_i) begin
            if (st_q[alloc_id_i] == ST_FREE) begin
               st_q[alloc_id_i]   <= ST_WAIT;
               addr_q[alloc_id_i] <= alloc_line_addr_i;
            end else begin
               err_q <= 1'b1;
            end
         end

         if (refill_done_vld_i) begin
            if (st_q[refill_done_id_i] == ST_WAIT) begin
               st_q[refill_done_id_i] <= ST_DONE;
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rvh_l1d_mshr_retire.sv
// Randomized and directed bench for rvh_l1d_mshr_retire with a per-entry lifecycle
// model and a retire-handshake scoreboard queue.
module tb_rvh_l1d_mshr_retire;

   localparam int N  = 4;
   localparam int W  = 2;
   localparam int AW = 26;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          alloc_vld_i = 1'b0;
   logic [W-1:0]  alloc_id_i = '0;
   logic [AW-1:0] alloc_line_addr_i = '0;
   logic          refill_done_vld_i = 1'b0;
   logic [W-1:0]  refill_done_id_i = '0;
   logic          retire_vld_o;
   logic          retire_rdy_i = 1'b0;
   logic [W-1:0]  retire_id_o;
   logic [AW-1:0] retire_line_addr_o;
   logic [N-1:0]  mshr_bank_valid_o;
   logic [N-1:0]  done_pending_o;
   logic          err_o;

   rvh_l1d_mshr_retire #(.N_MSHR(N), .N_MSHR_W(W), .LINE_ADDR_W(AW)) dut (
      .clk                (clk),
      .rst                (rst),
      .alloc_vld_i        (alloc_vld_i),
      .alloc_id_i         (alloc_id_i),
      .alloc_line_addr_i  (alloc_line_addr_i),
      .refill_done_vld_i  (refill_done_vld_i),
      .refill_done_id_i   (refill_done_id_i),
      .retire_vld_o       (retire_vld_o),
      .retire_rdy_i       (retire_rdy_i),
      .retire_id_o        (retire_id_o),
      .retire_line_addr_o (retire_line_addr_o),
      .mshr_bank_valid_o  (mshr_bank_valid_o),
      .done_pending_o     (done_pending_o),
      .err_o              (err_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- counters / scoreboard ----------------
   int n_total = 0;
   int n_pass  = 0;
   logic [W+AW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      else n_pass++;
   endtask

   // ---------------- reference model ----------------
   // Entry life: 0 = free, 1 = waiting for refill, 2 = refill done.
   int            m_st   [N];
   logic [AW-1:0] m_addr [N];
   int            m_rr = 0;
   bit            m_held = 0;
   int            m_held_id = 0;
   bit            m_err = 0;

   initial begin
      for (int i = 0; i < N; i++) begin
         m_st[i]   = 0;
         m_addr[i] = '0;
      end
      @(posedge clk);
      forever begin
         @(negedge clk);
         begin
            int  offer_id;
            bit  offer;
            int  pre [N];
            logic [N-1:0] e_valid, e_done;
            offer    = 0;
            offer_id = 0;
            if (m_held) begin
               offer    = 1;
               offer_id = m_held_id;
            end else begin
               for (int k = 0; k < N; k++) begin
                  if (!offer && m_st[(m_rr + k) % N] == 2) begin
                     offer    = 1;
                     offer_id = (m_rr + k) % N;
                  end
               end
            end
            for (int i = 0; i < N; i++) begin
               e_valid[i] = (m_st[i] != 0);
               e_done[i]  = (m_st[i] == 2);
            end
            chk("retire_vld", 32'(retire_vld_o), 32'(offer));
            if (offer) begin
               chk("retire_id", 32'(retire_id_o), 32'(offer_id));
               chk("retire_addr", 32'(retire_line_addr_o), 32'(m_addr[offer_id]));
            end
            chk("bank_valid", 32'(mshr_bank_valid_o), 32'(e_valid));
            chk("done_pending", 32'(done_pending_o), 32'(e_done));
            chk("err", 32'(err_o), 32'(m_err));

            if (rst) begin
               for (int i = 0; i < N; i++) begin
                  m_st[i]   = 0;
                  m_addr[i] = '0;
               end
               m_rr = 0; m_held = 0; m_held_id = 0; m_err = 0;
            end else begin
               for (int i = 0; i < N; i++) pre[i] = m_st[i];
               if (offer && retire_rdy_i) begin
                  exp_q.push_back({W'(offer_id), m_addr[offer_id]});
                  m_st[offer_id] = 0;
                  m_rr   = (offer_id + 1) % N;
                  m_held = 0;
               end else if (offer) begin
                  m_held    = 1;
                  m_held_id = offer_id;
               end
               if (alloc_vld_i) begin
                  if (pre[alloc_id_i] == 0) begin
                     m_st[alloc_id_i]   = 1;
                     m_addr[alloc_id_i] = alloc_line_addr_i;
                  end else m_err = 1;
               end
               if (refill_done_vld_i) begin
                  if (pre[refill_done_id_i] == 1) m_st[refill_done_id_i] = 2;
                  else m_err = 1;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         #1;
         if (!rst && retire_vld_o && retire_rdy_i) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL retire_unexpected at %0t: got id %0d with no retire expected", $time, retire_id_o);
            end else begin
               logic [W+AW-1:0] e;
               e = exp_q.pop_front();
               chk("hs_id", 32'(retire_id_o), 32'(e[W+AW-1:AW]));
               chk("hs_addr", 32'(retire_line_addr_o), 32'(e[AW-1:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic av, input int aid, input logic [AW-1:0] aa,
                        input logic rv, input int rid, input logic rdy);
      alloc_vld_i       = av;
      alloc_id_i        = W'(aid);
      alloc_line_addr_i = aa;
      refill_done_vld_i = rv;
      refill_done_id_i  = W'(rid);
      retire_rdy_i      = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, rdy);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(1, 0);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle(2, 0);
      rst = 1'b0;

      // single entry round trip
      drive(1, 0, 26'h123, 0, 0, 0);
      drive(0, 0, '0, 1, 0, 0);
      idle(1, 1);
      idle(2, 0);

      // four entries, out-of-order completion with ready high, then wrap
      for (int i = 0; i < N; i++) drive(1, i, AW'(26'h1000 + i), 0, 0, 0);
      drive(0, 0, '0, 1, 3, 1);
      drive(0, 0, '0, 1, 1, 1);
      drive(0, 0, '0, 1, 2, 1);
      idle(4, 1);
      drive(0, 0, '0, 1, 0, 1);
      idle(3, 1);

      // offer held under backpressure while another entry completes
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, i, AW'(26'h2000 + i), 0, 0, 0);
      drive(0, 0, '0, 1, 1, 0);
      drive(0, 0, '0, 1, 2, 0);
      drive(0, 0, '0, 1, 0, 0);
      idle(3, 0);
      idle(4, 1);

      // illegal alloc and illegal refill leave state intact, err sticky
      drive(1, 2, 26'h2AA, 0, 0, 0);
      drive(1, 2, 26'hABC, 0, 0, 0);
      drive(0, 0, '0, 1, 0, 0);
      drive(0, 0, '0, 1, 2, 0);
      idle(2, 1);
      idle(2, 0);

      // re-alloc in the handshake cycle is rejected, one cycle later accepted
      do_reset();
      drive(1, 3, 26'h333, 0, 0, 0);
      drive(0, 0, '0, 1, 3, 0);
      drive(1, 3, 26'h3F3, 0, 0, 1);
      drive(1, 3, 26'h3F4, 0, 0, 0);
      drive(0, 0, '0, 1, 3, 0);
      idle(1, 1);
      idle(1, 0);

      // reset while an offer is stalled, then a fresh sequence
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, i, AW'(26'h4000 + i), 0, 0, 0);
      drive(0, 0, '0, 1, 0, 0);
      idle(2, 0);
      do_reset();
      drive(1, 1, 26'h555, 0, 0, 0);
      drive(0, 0, '0, 1, 1, 0);
      idle(2, 1);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 199) == 0) rst = 1'b1;
         else rst = 1'b0;
         drive(logic'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), AW'($urandom),
               logic'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
               logic'($urandom_range(0, 9) < 6));
      end
      rst = 1'b0;
      idle(8, 1);

      n_total++;
      if (exp_q.size() != 0) $display("FAIL retire_drain: got %0d retires outstanding expected 0", exp_q.size());
      else n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
